// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch, branch targets, writeback redirects
// with a stall-pending register, and a circular return-address stack.
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     N_WB      = 2,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 do_update,
    input  logic                 br_valid,
    input  logic [1:0]           br_type,
    input  logic [XLEN-1:0]      br_imm,
    input  logic                 cond_go,
    input  logic [XLEN-1:0]      rf_d2,
    input  logic [N_WB-1:0]      wb_we,
    input  logic [4*N_WB-1:0]    wb_ws,
    input  logic [XLEN*N_WB-1:0] wb_wd,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      pc_plus4,
    output logic                 branch_taken,
    output logic                 redirect,
    output logic                 ras_empty,
    output logic                 ras_full
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] BR_B   = 2'd0;
    localparam logic [1:0] BR_BL  = 2'd1;
    localparam logic [1:0] BR_BX  = 2'd2;
    localparam logic [1:0] BR_RET = 2'd3;

    logic [XLEN-1:0]  r_pc;
    logic             r_pend_vld;
    logic [XLEN-1:0]  r_pend_pc;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_cnt;

    logic             w_wb_hit;
    logic [XLEN-1:0]  w_wb_data;
    logic             w_taken;
    logic [XLEN-1:0]  w_br_target;
    logic [XLEN-1:0]  w_next_pc;
    logic [XLEN-1:0]  w_ras_top;
    logic [PTR_W-1:0] w_top_inc;
    logic             w_push;
    logic             w_pop;

    assign pc        = r_pc;
    assign pc_plus4  = r_pc + XLEN'(4);
    assign ras_empty = (r_cnt == '0);
    assign ras_full  = (r_cnt == CNT_W'(RAS_DEPTH));
    assign w_ras_top = r_ras[r_top];
    assign w_top_inc = r_top + PTR_W'(1);

    // Lowest-index port writing r15 wins, so scan from the top down.
    always_comb begin
        w_wb_hit  = 1'b0;
        w_wb_data = '0;
        for (int i = int'(N_WB) - 1; i >= 0; i--) begin
            if (wb_we[i] && (wb_ws[4*i +: 4] == 4'hF)) begin
                w_wb_hit  = 1'b1;
                w_wb_data = wb_wd[XLEN*i +: XLEN];
            end
        end
    end

    always_comb begin
        w_taken     = br_valid & cond_go;
        w_br_target = r_pc + br_imm;
        case (br_type)
            BR_B, BR_BL: w_br_target = r_pc + br_imm;
            BR_BX:       w_br_target = rf_d2;
            BR_RET:      w_br_target = ras_empty ? rf_d2 : w_ras_top;
            default:     w_br_target = r_pc + br_imm;
        endcase
    end

    // Next-PC priority: wb redirect, pending redirect, taken branch, sequential.
    always_comb begin
        w_next_pc    = pc_plus4;
        redirect     = 1'b0;
        branch_taken = 1'b0;
        if (w_wb_hit) begin
            w_next_pc    = w_wb_data;
            redirect     = 1'b1;
            branch_taken = 1'b1;
        end else if (r_pend_vld) begin
            w_next_pc    = r_pend_pc;
            redirect     = 1'b1;
            branch_taken = 1'b1;
        end else if (w_taken) begin
            w_next_pc    = w_br_target;
            branch_taken = 1'b1;
        end
    end

    assign w_push = do_update & ~redirect & w_taken & (br_type == BR_BL);
    assign w_pop  = do_update & ~redirect & w_taken & (br_type == BR_RET);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pc       <= RESET_VEC;
            r_pend_vld <= 1'b0;
            r_pend_pc  <= '0;
        end else if (do_update) begin
            r_pc       <= w_next_pc;
            r_pend_vld <= 1'b0;
        end else if (w_wb_hit) begin
            r_pend_vld <= 1'b1;
            r_pend_pc  <= w_wb_data;
        end
    end

    // Push while full wraps onto the oldest slot; pop while empty is a no-op.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_top <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_top <= w_top_inc;
            if (!ras_full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_pop && !ras_empty) begin
            r_top <= r_top - PTR_W'(1);
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_top_inc] <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues hand-computed expectations per
// cycle and a negedge monitor pops and compares them against the outputs.
module tb_pc_gen;

    logic        clk;
    logic        nreset;
    logic        do_update;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [31:0] br_imm;
    logic        cond_go;
    logic [31:0] rf_d2;
    logic [1:0]  wb_we;
    logic [7:0]  wb_ws;
    logic [63:0] wb_wd;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic        redirect;
    logic        ras_empty;
    logic        ras_full;

    pc_gen #(.XLEN(32), .N_WB(2), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut (
        .clk(clk), .nreset(nreset), .do_update(do_update),
        .br_valid(br_valid), .br_type(br_type), .br_imm(br_imm),
        .cond_go(cond_go), .rf_d2(rf_d2),
        .wb_we(wb_we), .wb_ws(wb_ws), .wb_wd(wb_wd),
        .pc(pc), .pc_plus4(pc_plus4), .branch_taken(branch_taken),
        .redirect(redirect), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        bt;
        logic        rd;
        logic        emp;
        logic        full;
    } exp_t;

    exp_t q[$];
    logic chk_vld;
    int   step_id;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
        end
    endtask

    // Monitor: every flagged cycle consumes one expectation.
    always @(negedge clk) begin
        if (chk_vld) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                cmp("pc", e.id, pc, e.pc);
                cmp("pc_plus4", e.id, pc_plus4, e.pc + 32'd4);
                cmp("branch_taken", e.id, 32'(branch_taken), 32'(e.bt));
                cmp("redirect", e.id, 32'(redirect), 32'(e.rd));
                cmp("ras_empty", e.id, 32'(ras_empty), 32'(e.emp));
                cmp("ras_full", e.id, 32'(ras_full), 32'(e.full));
            end
        end
    end

    task automatic step(input logic [31:0] epc, input logic ebt, input logic erd,
                        input logic eemp, input logic efull);
        exp_t e;
        e.id = step_id; e.pc = epc; e.bt = ebt; e.rd = erd; e.emp = eemp; e.full = efull;
        q.push_back(e);
        step_id++;
        chk_vld = 1'b1;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    task automatic setin(input logic du, input logic bv, input logic [1:0] bt,
                         input logic [31:0] imm, input logic cg, input logic [31:0] d2);
        do_update = du; br_valid = bv; br_type = bt; br_imm = imm; cond_go = cg; rf_d2 = d2;
    endtask

    task automatic setwb(input logic [1:0] we, input logic [7:0] ws,
                         input logic [31:0] d0, input logic [31:0] d1);
        wb_we = we; wb_ws = ws; wb_wd = {d1, d0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; step_id = 0; chk_vld = 1'b0;
        nreset = 1'b0;
        setin(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        setwb(2'b00, 8'h00, 32'h0, 32'h0);
        @(posedge clk); #1;
        step(32'h0, 0, 0, 1, 0);                      // in reset
        nreset = 1'b1;

        // Sequential fetch then a stall.
        setin(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        step(32'h0, 0, 0, 1, 0);
        step(32'h4, 0, 0, 1, 0);
        step(32'h8, 0, 0, 1, 0);
        setin(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        step(32'hC, 0, 0, 1, 0);
        step(32'hC, 0, 0, 1, 0);

        // BX to 0x100, BL +0x40, RET back to 0x104.
        setin(1'b1, 1'b1, 2'd2, 32'h0, 1'b1, 32'h100);
        step(32'hC, 1, 0, 1, 0);
        setin(1'b1, 1'b1, 2'd1, 32'h40, 1'b1, 32'h0);
        step(32'h100, 1, 0, 1, 0);
        setin(1'b1, 1'b1, 2'd3, 32'h0, 1'b1, 32'hDEAD);
        step(32'h140, 1, 0, 0, 0);
        // br_valid=0 ignores branch fields; cond_go=0 is not taken.
        setin(1'b1, 1'b0, 2'd2, 32'h40, 1'b1, 32'hDEAD);
        step(32'h104, 0, 0, 1, 0);
        setin(1'b1, 1'b1, 2'd0, 32'h40, 1'b0, 32'h0);
        step(32'h108, 0, 0, 1, 0);

        // Dual wb redirect over a taken B; then port1 only, with a BL that must not push.
        setin(1'b1, 1'b1, 2'd0, 32'h40, 1'b1, 32'h0);
        setwb(2'b11, 8'hFF, 32'h200, 32'h300);
        step(32'h10C, 1, 1, 1, 0);
        setin(1'b1, 1'b1, 2'd1, 32'h40, 1'b1, 32'h0);
        setwb(2'b11, 8'hF3, 32'h250, 32'h300);
        step(32'h200, 1, 1, 1, 0);

        // Stall with two wb redirects, then release.
        setin(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        setwb(2'b01, 8'h0F, 32'h500, 32'h0);
        step(32'h300, 1, 1, 1, 0);
        setwb(2'b01, 8'h0F, 32'h600, 32'h0);
        step(32'h300, 1, 1, 1, 0);
        setwb(2'b00, 8'h00, 32'h0, 32'h0);
        step(32'h300, 1, 1, 1, 0);
        setin(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        step(32'h300, 1, 1, 1, 0);
        step(32'h600, 0, 0, 1, 0);

        // Five BL pushes into a 4-deep stack.
        setin(1'b1, 1'b1, 2'd1, 32'h100, 1'b1, 32'h0);
        step(32'h604, 1, 0, 1, 0);
        step(32'h704, 1, 0, 0, 0);
        step(32'h804, 1, 0, 0, 0);
        step(32'h904, 1, 0, 0, 0);
        step(32'hA04, 1, 0, 0, 1);
        // Five RETs: four LIFO returns, the fifth falls back to rf_d2.
        setin(1'b1, 1'b1, 2'd3, 32'h0, 1'b1, 32'hC00);
        step(32'hB04, 1, 0, 0, 1);
        step(32'hA08, 1, 0, 0, 0);
        step(32'h908, 1, 0, 0, 0);
        step(32'h808, 1, 0, 0, 0);
        step(32'h708, 1, 0, 1, 0);
        setin(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        step(32'hC00, 0, 0, 1, 0);

        // Build RAS and pending state, then reset mid-stall.
        setin(1'b1, 1'b1, 2'd1, 32'h10, 1'b1, 32'h0);
        step(32'hC04, 1, 0, 1, 0);
        setin(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        setwb(2'b01, 8'h0F, 32'h700, 32'h0);
        step(32'hC14, 1, 1, 0, 0);
        setwb(2'b00, 8'h00, 32'h0, 32'h0);
        step(32'hC14, 1, 1, 0, 0);
        #1;
        nreset = 1'b0;
        step(32'h0, 0, 0, 1, 0);
        nreset = 1'b1;
        setin(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        step(32'h0, 0, 0, 1, 0);
        step(32'h4, 0, 0, 1, 0);

        @(posedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL take parameters, one per line: name, default, meaning.
- XLEN, 32, address width
- N_WB, 2, number of writeback redirect ports
- RESET_VEC, 0, PC value after reset
- RAS_DEPTH, 4, return-address-stack entries (power of two, >=2)

REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge
- nreset, in, 1, asynchronous active-low reset
- do_update, in, 1, PC advance enable (0 = stall)
- br_valid, in, 1, decode-stage instruction is a branch
- br_type, in, 2, branch kind: 0 B, 1 BL, 2 BX, 3 RET
- br_imm, in, XLEN, sign-extended byte offset, relative to current pc
- cond_go, in, 1, branch condition passes
- rf_d2, in, XLEN, register operand for BX and for a RET with an empty RAS
- wb_we, in, N_WB, per-port write enable
- wb_ws, in, 4*N_WB, per-port destination register (port i at bits [4i+3:4i])
- wb_wd, in, XLEN*N_WB, per-port write data
- pc, out, XLEN, current PC
- pc_plus4, out, XLEN, pc+4
- branch_taken, out, 1, next_pc differs from pc_plus4 path this cycle
- redirect, out, 1, a writeback or pending redirect selects next_pc this cycle
- ras_empty, out, 1, RAS holds 0 entries
- ras_full, out, 1, RAS holds RAS_DEPTH entries

Function
REQ-003 SHALL compute pc_plus4 = pc + 4 modulo 2^XLEN, combinationally.
REQ-004 SHALL treat wb port i as redirecting when wb_we[i]=1 and wb_ws[i]=15; the lowest-index redirecting port wins.
REQ-005 SHALL select next_pc in this priority order:
- winning wb redirect data
- pending redirect register
- taken branch (br_valid & cond_go)
- pc_plus4
REQ-006 SHALL use these taken-branch targets:
- B/BL: pc + br_imm, wrapping
- BX: rf_d2
- RET: RAS top if not empty, else rf_d2
REQ-007 SHALL drive branch_taken=1 whenever next_pc is not from pc_plus4, and redirect=1 when the first or second source in REQ-005 is selected; both outputs are combinational.
REQ-008 SHALL load pc <= next_pc on a rising clk edge only when do_update=1; otherwise hold pc.
REQ-009 SHALL capture the winning wb redirect data into the pending register, and set its valid bit, when a wb redirect occurs with do_update=0; a later wb redirect during the same stall overwrites it.
REQ-010 SHALL clear the pending valid bit on the first edge with do_update=1 and no new wb redirect; a wb redirect on that edge takes priority and the pending bit also clears.
REQ-011 SHALL update the RAS only on edges with do_update=1 and no redirect selected:
- taken BL: push pc_plus4
- taken RET: pop
- B and BX: leave the RAS unchanged
REQ-012 SHALL, on a push while full, overwrite the oldest entry (circular); the count stays at RAS_DEPTH and the top becomes the new value.
REQ-013 SHALL, on a pop while empty, leave the RAS unchanged, with count held at 0.
REQ-014 SHALL ignore br_type, br_imm and cond_go when br_valid=0, and SHALL ignore rf_d2 except as REQ-006 uses it.

Reset
REQ-015 SHALL, while nreset=0 and independent of clk, set:
- pc = RESET_VEC
- pending valid = 0
- RAS count = 0 (ras_empty=1, ras_full=0)
REQ-016 SHALL NOT require the RAS entry storage to be reset.
REQ-017 SHALL abort any stall, pending redirect or RAS state when reset is asserted mid-operation; the first update after release fetches from RESET_VEC+4.

Verification
REQ-018 Reset, then hold do_update=1 for 3 cycles -> pc steps 0,4,8,12; branch_taken=0.
REQ-019 pc=0x100, taken BL with br_imm=0x40 -> pc=0x140, RAS top=0x104; then a taken RET -> pc=0x104, ras_empty=1.
REQ-020 Both wb ports write r15 (port0 0x200, port1 0x300) while a taken B is present -> pc=0x200, redirect=1.
REQ-021 do_update=0 with wb redirect 0x500, then 0x600, then do_update=1 with no wb activity -> pc=0x600, pending valid cleared.
REQ-022 5 BL pushes with RAS_DEPTH=4, then 5 RETs -> first 4 RETs return the last 4 pushed addresses LIFO, ras_full=1 after the 4th push; the 5th RET uses rf_d2.
REQ-023 nreset pulsed low mid-stall with a pending redirect -> pc=RESET_VEC immediately, the pending redirect is discarded, ras_empty=1.
